// File: rtl/adc_evb_pkg.sv
// rtl/adc_evb_pkg.sv - shared constants, state type and window helper for the ADC event builder
package adc_evb_pkg;

  localparam int NCH           = 64;
  localparam int ADC_BITS      = 12;
  localparam int DEPTH         = 256;
  localparam int AW            = 8;
  localparam int ROW_W         = NCH * ADC_BITS;
  localparam int WORDS_PER_ROW = 32;

  localparam logic [15:0] HDR_MAGIC = 16'hAD5A;
  localparam logic [15:0] FTR_MAGIC = 16'hEEEE;

  typedef enum logic [2:0] {IDLE, CAPTURE, HDR0, HDR1, DATA, FOOTER} state_t;

  // Effective samples per event: zero means one sample, anything above DEPTH clamps to DEPTH.
  function automatic logic [8:0] window_n(input logic [8:0] reg_window);
    logic [8:0] n;
    if (reg_window == 9'd0) begin
      n = 9'd1;
    end else if (reg_window > 9'(DEPTH)) begin
      n = 9'(DEPTH);
    end else begin
      n = reg_window;
    end
    return n;
  endfunction

endpackage

// File: rtl/adc_evb_row_buf.sv
// rtl/adc_evb_row_buf.sv - DEPTH x 768-bit sample buffer, one write port and one registered read port
module adc_evb_row_buf
  import adc_evb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [ROW_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [ROW_W-1:0] o_rd_data
);

  logic [ROW_W-1:0] r_mem [DEPTH];
  logic [ROW_W-1:0] r_rd_data;

  // Write one captured sample row.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; the row register holds its value until the next read strobe.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/adc_event_builder.sv
// rtl/adc_event_builder.sv - captures a trigger window of ADC samples and streams it as a framed event
module adc_event_builder
  import adc_evb_pkg::*;
(
  input  logic                      SYSCLK,
  input  logic                      sRST,
  input  logic                      ENABLE,
  input  logic [8:0]                REG_WINDOW,
  input  logic                      RAW_SOD,
  input  logic [31:0]               RAW_TRG_NUM,
  input  logic [NCH*ADC_BITS-1:0]   RAW_ADC,
  output logic [31:0]               OUT_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      BUSY,
  output logic [15:0]               DROP_CNT
);

  state_t           r_state, w_state_nxt;
  logic [8:0]       r_n;
  logic [31:0]      r_trg;
  logic [8:0]       r_wr_row;
  logic [8:0]       r_s;
  logic [4:0]       r_k;
  logic             r_ftr_loaded;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic [15:0]      r_drop_cnt;

  logic [8:0]       w_n_sod;
  logic             w_sod_accept;
  logic             w_free;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic             w_load;
  logic [31:0]      w_load_word;
  logic [ROW_W-1:0] w_rd_data;
  logic [9:0]       w_bit_base;
  logic [23:0]      w_pair;

  assign w_n_sod      = window_n(REG_WINDOW);
  assign w_sod_accept = (r_state == IDLE) && RAW_SOD && ENABLE;
  // The output register can take a new word when empty or when its word leaves this cycle.
  assign w_free       = !r_out_valid || OUT_READY;
  // Word k of a row carries channels 2k and 2k+1, i.e. 24 consecutive bits.
  assign w_bit_base   = 10'(r_k) * 10'd24;
  assign w_pair       = w_rd_data[w_bit_base +: 24];

  adc_evb_row_buf u_row_buf (
    .i_clk     (SYSCLK),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (RAW_ADC),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // State register.
  always_ff @(posedge SYSCLK) begin
    if (sRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, buffer strobes and the word offered to the output register.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_row[AW-1:0];
    w_rd_en     = 1'b0;
    w_rd_addr   = r_s[AW-1:0];
    w_load      = 1'b0;
    w_load_word = 32'd0;
    case (r_state)
      IDLE: begin
        if (RAW_SOD && ENABLE) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = '0;
          w_state_nxt = (w_n_sod == 9'd1) ? HDR0 : CAPTURE;
        end
      end
      CAPTURE: begin
        w_wr_en = 1'b1;
        if (r_wr_row == r_n - 9'd1) begin
          w_state_nxt = HDR0;
        end
      end
      HDR0: begin
        // Prefetch row 0 here so it is in the row register before the first data word.
        w_rd_en   = 1'b1;
        w_rd_addr = '0;
        if (w_free) begin
          w_load      = 1'b1;
          w_load_word = {HDR_MAGIC, 7'd0, r_n};
          w_state_nxt = HDR1;
        end
      end
      HDR1: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_word = r_trg;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_word = {4'h0, w_pair[23:12], 4'h0, w_pair[11:0]};
          // Last word of the row: fetch the next row on the same edge, so there is no bubble.
          if (r_k == 5'(WORDS_PER_ROW - 1)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_s[AW-1:0] + AW'(1);
            if (r_s == r_n - 9'd1) begin
              w_state_nxt = FOOTER;
            end
          end
        end
      end
      FOOTER: begin
        if (r_ftr_loaded) begin
          if (OUT_READY) begin
            w_state_nxt = IDLE;
          end
        end else if (w_free) begin
          w_load      = 1'b1;
          w_load_word = {FTR_MAGIC, 2'b00, r_n, 5'd0};
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Event bookkeeping: window, trigger number, write row and read position.
  always_ff @(posedge SYSCLK) begin
    if (sRST) begin
      r_n          <= 9'd1;
      r_trg        <= '0;
      r_wr_row     <= '0;
      r_s          <= '0;
      r_k          <= '0;
      r_ftr_loaded <= 1'b0;
    end else begin
      if (w_sod_accept) begin
        r_n      <= w_n_sod;
        r_trg    <= RAW_TRG_NUM;
        r_wr_row <= 9'd1;
      end
      if (r_state == CAPTURE) begin
        r_wr_row <= r_wr_row + 9'd1;
      end
      if (r_state == HDR1 && w_load) begin
        r_s <= '0;
        r_k <= '0;
      end
      if (r_state == DATA && w_load) begin
        r_k <= r_k + 5'd1;
        if (r_k == 5'(WORDS_PER_ROW - 1)) begin
          r_s <= r_s + 9'd1;
        end
      end
      if (r_state == FOOTER && w_load) begin
        r_ftr_loaded <= 1'b1;
      end
      if (r_state == IDLE) begin
        r_ftr_loaded <= 1'b0;
      end
    end
  end

  // Output register: load a new word when free, otherwise drop valid once the word is taken.
  always_ff @(posedge SYSCLK) begin
    if (sRST) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_load_word;
      r_out_valid <= 1'b1;
    end else if (OUT_READY) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of triggers arriving while an event is in progress.
  always_ff @(posedge SYSCLK) begin
    if (sRST) begin
      r_drop_cnt <= '0;
    end else if (RAW_SOD && (r_state != IDLE) && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = (r_state != IDLE);
  assign DROP_CNT  = r_drop_cnt;

endmodule

// File: tb/tb_adc_event_builder.sv
// tb/tb_adc_event_builder.sv - randomized self-checking bench for adc_event_builder
module tb_adc_event_builder;

  logic         SYSCLK;
  logic         sRST;
  logic         ENABLE;
  logic [8:0]   REG_WINDOW;
  logic         RAW_SOD;
  logic [31:0]  RAW_TRG_NUM;
  logic [767:0] RAW_ADC;
  logic [31:0]  OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic         BUSY;
  logic [15:0]  DROP_CNT;

  int n_cmp = 0;
  int n_mis = 0;
  int ready_mode = 0;
  int exp_drops = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int unsigned chv [256][64];
  bit prev_stall = 0;
  logic [31:0] prev_data = '0;

  adc_event_builder dut (
    .SYSCLK      (SYSCLK),
    .sRST        (sRST),
    .ENABLE      (ENABLE),
    .REG_WINDOW  (REG_WINDOW),
    .RAW_SOD     (RAW_SOD),
    .RAW_TRG_NUM (RAW_TRG_NUM),
    .RAW_ADC     (RAW_ADC),
    .OUT_DATA    (OUT_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .BUSY        (BUSY),
    .DROP_CNT    (DROP_CNT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Downstream readiness pattern.
  always @(posedge SYSCLK) begin
    #1;
    case (ready_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = 1'($urandom_range(0, 1));
      2:       OUT_READY = ($urandom_range(0, 9) != 0);
      default: OUT_READY = 1'b0;
    endcase
  end

  // Stream monitor: collect transferred words, check stall stability and idle silence.
  always @(negedge SYSCLK) begin
    if (sRST) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("stall_data", OUT_DATA, prev_data);
      end
      chk("valid_while_idle", {31'd0, OUT_VALID & ~BUSY}, 32'd0);
      if (OUT_VALID && OUT_READY) got_q.push_back(OUT_DATA);
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
    end
  end

  function automatic int eff_n(input int wreg);
    if (wreg == 0) return 1;
    if (wreg > 256) return 256;
    return wreg;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic drive_row(input int s);
    logic [767:0] v;
    for (int c = 0; c < 64; c++) v[12*c +: 12] = 12'(chv[s][c]);
    RAW_ADC = v;
  endtask

  // Drive one accepted event (SOD plus capture cycles) and queue its expected words.
  task automatic start_event(input int wreg, input logic [31:0] trg, input bit pat,
                             input int drop_a, input int drop_b);
    int n;
    n = eff_n(wreg);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < 64; c++)
        chv[s][c] = pat ? ((c + 16 * s) % 4096) : $urandom_range(0, 4095);
    ENABLE      = 1'b1;
    REG_WINDOW  = 9'(wreg);
    RAW_TRG_NUM = trg;
    RAW_SOD     = 1'b1;
    drive_row(0);
    @(posedge SYSCLK); #1;
    RAW_SOD     = 1'b0;
    REG_WINDOW  = 9'($urandom_range(0, 511));
    RAW_TRG_NUM = $urandom;
    for (int s = 1; s < n; s++) begin
      RAW_SOD = (s == drop_a) || (s == drop_b);
      drive_row(s);
      @(posedge SYSCLK); #1;
    end
    RAW_SOD = 1'b0;
    RAW_ADC = {24{$urandom}};
    exp_q.push_back(32'hAD5A0000 | 32'(n));
    exp_q.push_back(trg);
    for (int s = 0; s < n; s++)
      for (int k = 0; k < 32; k++)
        exp_q.push_back(32'((chv[s][2*k+1] << 16) | chv[s][2*k]));
    exp_q.push_back(32'hEEEE0000 | ((32'(n) * 32) & 32'hFFFF));
  endtask

  task automatic drain(input string tag);
    int cyc;
    int m;
    cyc = 0;
    while ((BUSY || got_q.size() < exp_q.size()) && cyc < 20000) begin
      @(posedge SYSCLK); #1;
      cyc++;
    end
    if (cyc >= 20000) chk({tag, "_timeout"}, {31'd0, BUSY}, 32'd0);
    repeat (3) begin @(posedge SYSCLK); #1; end
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    bit found;
    bit busy_seen;
    sRST = 1'b1; ENABLE = 1'b0; REG_WINDOW = '0; RAW_SOD = 1'b0;
    RAW_TRG_NUM = '0; RAW_ADC = '0;
    repeat (3) @(posedge SYSCLK);
    #1; sRST = 1'b0;
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_drop", {16'd0, DROP_CNT}, 32'd0);

    // Basic event with the channel ramp pattern.
    ready_mode = 0;
    start_event(2, 32'h12345678, 1'b1, -1, -1);
    drain("basic");
    chk("basic_count", 32'(got_q.size()), 32'd67);
    chk("basic_hdr0", got_q[0], 32'hAD5A0002);
    chk("basic_hdr1", got_q[1], 32'h12345678);
    chk("basic_data0", got_q[2], 32'h00010000);
    chk("basic_data32", got_q[34], 32'h00110010);
    chk("basic_footer", got_q[66], 32'hEEEE0040);
    clear_q();

    // Same event under random backpressure.
    ready_mode = 1;
    start_event(2, 32'h12345678, 1'b1, -1, -1);
    drain("bp");
    clear_q();

    // Window zero means one sample.
    start_event(0, $urandom, 1'b0, -1, -1);
    drain("win0");
    chk("win0_hdr0", got_q[0], 32'hAD5A0001);
    chk("win0_footer", got_q[got_q.size()-1], 32'hEEEE0020);
    clear_q();

    // Random windows and data.
    for (int i = 0; i < 6; i++) begin
      start_event($urandom_range(1, 40), $urandom, 1'b0, -1, -1);
      drain($sformatf("rand%0d", i));
      clear_q();
    end

    // Oversized window clamps to the buffer depth.
    ready_mode = 2;
    start_event(300, $urandom, 1'b0, -1, -1);
    drain("win300");
    chk("win300_hdr0", got_q[0], 32'hAD5A0100);
    chk("win300_count", 32'(got_q.size()), 32'd8195);
    chk("win300_footer", got_q[got_q.size()-1], 32'hEEEE2000);
    clear_q();

    // Drops: two SODs during capture, one during data.
    ready_mode = 0;
    start_event(10, $urandom, 1'b0, 3, 7);
    cyc = 0;
    while (got_q.size() < 20 && cyc < 500) begin @(posedge SYSCLK); #1; cyc++; end
    if (cyc >= 500) chk("drop_wait_timeout", 32'(got_q.size()), 32'd20);
    RAW_SOD = 1'b1; RAW_TRG_NUM = $urandom;
    @(posedge SYSCLK); #1;
    RAW_SOD = 1'b0;
    exp_drops = sat16(exp_drops + 3);
    drain("drops");
    chk("drops_cnt", {16'd0, DROP_CNT}, 32'(exp_drops));
    clear_q();

    // SOD coincident with the footer transfer is a drop; the next cycle's SOD is accepted.
    ready_mode = 0;
    start_event(3, $urandom, 1'b0, -1, -1);
    found = 0; cyc = 0;
    while (!found && cyc < 2000) begin
      @(negedge SYSCLK);
      cyc++;
      if (OUT_VALID && OUT_READY && OUT_DATA == 32'hEEEE0060) found = 1;
    end
    if (!found) chk("ftr_edge_timeout", OUT_DATA, 32'hEEEE0060);
    RAW_SOD = 1'b1;
    @(posedge SYSCLK); #1;
    RAW_SOD = 1'b0;
    exp_drops = sat16(exp_drops + 1);
    chk("ftr_edge_idle", {31'd0, BUSY}, 32'd0);
    start_event(1, $urandom, 1'b0, -1, -1);
    drain("ftr_edge");
    chk("ftr_edge_drop", {16'd0, DROP_CNT}, 32'(exp_drops));
    clear_q();

    // Disabled: SODs are ignored entirely.
    ENABLE = 1'b0; busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      RAW_SOD = (i % 5 == 0);
      RAW_TRG_NUM = $urandom;
      @(posedge SYSCLK); #1;
      busy_seen |= BUSY;
    end
    RAW_SOD = 1'b0;
    repeat (5) begin @(posedge SYSCLK); #1; end
    chk("dis_busy", {31'd0, busy_seen}, 32'd0);
    chk("dis_words", 32'(got_q.size()), 32'd0);
    chk("dis_drop", {16'd0, DROP_CNT}, 32'(exp_drops));
    clear_q();

    // Drop counter saturation while the stream is stalled in the header.
    ready_mode = 3;
    start_event(4, $urandom, 1'b0, -1, -1);
    RAW_SOD = 1'b1;
    repeat (65540) begin @(posedge SYSCLK); #1; end
    RAW_SOD = 1'b0;
    exp_drops = sat16(exp_drops + 65540);
    chk("sat_drop", {16'd0, DROP_CNT}, 32'(exp_drops));
    ready_mode = 0;
    drain("sat_event");
    clear_q();

    // Reset in the middle of the data phase.
    start_event(4, $urandom, 1'b0, -1, -1);
    cyc = 0;
    while (got_q.size() < 10 && cyc < 500) begin @(posedge SYSCLK); #1; cyc++; end
    if (cyc >= 500) chk("rst_wait_timeout", 32'(got_q.size()), 32'd10);
    sRST = 1'b1;
    @(posedge SYSCLK); #1;
    sRST = 1'b0;
    exp_drops = 0;
    chk("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_drop", {16'd0, DROP_CNT}, 32'd0);
    clear_q();
    start_event(3, $urandom, 1'b0, -1, -1);
    drain("post_rst");
    chk("post_rst_hdr0", got_q[0], 32'hAD5A0003);
    clear_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/adc_event_builder.md
Name: adc_event_builder

Overview:
- Downstream consumer of the ADC delay-ring stage, clocked on SYSCLK.
- On each RAW_SOD it captures a programmable window of consecutive 64-channel x 12-bit samples, tagged with RAW_TRG_NUM, into an internal sample buffer.
- It then serialises the event as a framed 32-bit word stream toward the SiTCP TX FIFO, using valid/ready flow control.
- Triggers that arrive while an event is in progress are dropped and counted.

Parameters:
- NCH, 64, number of ADC channels.
- ADC_BITS, 12, bits per channel sample.
- DEPTH, 256, maximum samples per event (buffer rows).
- AW, 8, buffer address width, log2(DEPTH).

Ports:
- SYSCLK  in  1  system clock; the only clock.
- sRST  in  1  reset; synchronous, active-high.
- ENABLE  in  1  arms trigger acceptance.
- REG_WINDOW  in  9  requested samples per event.
- RAW_SOD  in  1  start of data; RAW_ADC is sample 0 in the same cycle.
- RAW_TRG_NUM  in  32  trigger number; sampled on RAW_SOD.
- RAW_ADC  in  768  delayed ADC data; ch c = [12c+11:12c].
- OUT_DATA  out  32  stream word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream FIFO can accept.
- BUSY  out  1  high in every state except IDLE.
- DROP_CNT  out  16  dropped-trigger count, saturating.

Behaviour:
- Reset: state=IDLE; OUT_VALID=0, OUT_DATA=0, BUSY=0, DROP_CNT=0. A reset mid-event discards the partial event with no footer; buffer contents are don't-care.
- Window size N, latched at SOD:
  - REG_WINDOW=0 gives N=1.
  - REG_WINDOW>DEPTH gives N=DEPTH.
  - Otherwise N=REG_WINDOW.
  - A later change to REG_WINDOW does not affect the event in progress.
- States: IDLE -> CAPTURE -> HDR0 -> HDR1 -> DATA -> FOOTER -> IDLE.
- IDLE:
  - RAW_SOD & ENABLE: latch trigger number and N, write RAW_ADC to row 0, go to CAPTURE (or straight to HDR0 if N=1).
  - RAW_SOD & !ENABLE: ignored, not counted.
- CAPTURE:
  - Writes RAW_ADC to rows 1..N-1 on consecutive cycles; no gaps, OUT_READY ignored.
  - Leaves for HDR0 after the cycle that writes row N-1.
- Drops: RAW_SOD in any non-IDLE state increments DROP_CNT (held at 0xFFFF) and leaves the current event intact.
- Output framing, in order:
  - HDR0 = {16'hAD5A, 7'd0, N[8:0]}, where N=256 encodes as 9'h100.
  - HDR1 = latched trigger number.
  - DATA: 32*N words. For sample s and word k (0..31), word = {4'h0, ch[2k+1], 4'h0, ch[2k]}; s-major, k-minor.
  - FOOTER = {16'hEEEE, 32*N as 16 bits}.
- Handshake:
  - A word transfers when OUT_VALID & OUT_READY.
  - While OUT_VALID & !OUT_READY, OUT_DATA holds stable and OUT_VALID stays high.
  - OUT_VALID never drops before transfer.
  - OUT_VALID is 0 in IDLE and CAPTURE.
- Buffer read: synchronous 1-cycle RAM with a 768-bit row register.
- Throughput: with OUT_READY tied high, at most one bubble per row. The full event (N=256) completes in no more than 32N+N+3 cycles after capture.
- FOOTER transfer returns to IDLE. RAW_SOD in the same cycle as the footer transfer is a drop; the first accepted SOD is in the cycle after.

Decomposition:
- Package adc_evb_pkg:
  - NCH, ADC_BITS, WORDS_PER_ROW=32.
  - Constants HDR_MAGIC=16'hAD5A and FTR_MAGIC=16'hEEEE.
  - State enum {IDLE, CAPTURE, HDR0, HDR1, DATA, FOOTER}.
- Sub-module adc_evb_row_buf: simple dual-port RAM, DEPTH x 768, write port plus registered read port; inferred, no vendor IP.
- Top level holds the FSM, counters, output register and handshake.

Test Plan:
- Basic event: REG_WINDOW=2, RAW_TRG_NUM=0x12345678, OUT_READY=1, ch[c]=c+16*s. Expect 67 words: 0xAD5A0002, 0x12345678, first data word 0x00010000, word 32 = 0x00110010, footer 0xEEEE0040.
- Backpressure: same event with OUT_READY toggling 1/0 pseudo-randomly. Expect an identical word sequence and OUT_DATA stable during every stall.
- Window bounds: REG_WINDOW=0 gives HDR0 0xAD5A0001 and footer 0xEEEE0020. REG_WINDOW=300 gives HDR0 0xAD5A0100, 8192 data words, and footer 0xEEEE2000.
- Drops: three SODs during CAPTURE/DATA of one event give DROP_CNT=3 and only one event output. With DROP_CNT preset via 65540 drops, it reads 0xFFFF.
- Reset mid-stream: assert sRST in DATA after 10 words. Next cycle OUT_VALID=0, BUSY=0, DROP_CNT=0; the next SOD yields a clean event starting with HDR0.
- ENABLE=0: RAW_SOD is ignored, BUSY stays 0, DROP_CNT is unchanged, no output.
